udp_stream_parser: RTL and testbench
====================================

// Module: udp_stream_parser
// PURPOSE
//  Byte-stream UDP/IPv4 receive parser; sits between an input fifo_ctrl and an output fifo_ctrl in the UDP path.
//  Strips the optional Ethernet header, IPv4 header and UDP header; filters on destination port; forwards payload with sof/eof.
//  Trims link padding, flags truncated frames, and keeps accept/drop statistics.
// PARAMETERS
//  ETH_HDR     1        1: frame starts with a 14-byte Ethernet header (ethertype checked); 0: frame starts at the IPv4 header
//  FILTER_EN   1        1: accept only dst ports listed in PORT_LIST; 0: accept every UDP dst port
//  NUM_PORTS   4        number of 16-bit entries in PORT_LIST (1..8)
//  PORT_LIST   64'h0    NUM_PORTS*16 bits; entry i = PORT_LIST[16*i +: 16]
//  CNT_WIDTH   32       width of the statistics counters
// PORTS
//  clk           in   1          single clock
//  reset         in   1          synchronous reset, active-low (0 = reset)
//  in_empty      in   1          input FIFO empty; in_dout/in_sof/in_eof are valid when 0 (first-word fall-through)
//  in_dout       in   8          input byte
//  in_sof        in   1          current input byte is the first of its frame
//  in_eof        in   1          current input byte is the last of its frame
//  in_rd_en      out  1          pop the input FIFO this cycle
//  out_full      in   1          output FIFO full
//  out_wr_en     out  1          write out_din to the output FIFO this cycle
//  out_din       out  8          payload byte
//  out_sof       out  1          first payload byte of the datagram
//  out_eof       out  1          last payload byte of the datagram
//  src_ip        out  32         IPv4 source address of the current datagram (held until next accept)
//  src_port      out  16         UDP source port (held until next accept)
//  err_trunc     out  1          1-cycle pulse: frame ended before udp_len payload bytes were delivered
//  pkt_count     out  CNT_WIDTH  datagrams forwarded (wraps)
//  drop_count    out  CNT_WIDTH  frames dropped (wraps)
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state IDLE; all outputs 0; counters 0; header capture registers 0. Reset mid-frame abandons the frame silently.
//  A pop occurs when in_rd_en==1. in_rd_en = !in_empty && (state!=PAYLOAD || !out_full).
//  Header bytes and DRAIN bytes are consumed regardless of out_full.
//  Offsets: B = 14 if ETH_HDR else 0; header length H = B+28.
//  States:
//   IDLE:  pop bytes. A byte with in_sof=0 is discarded. A byte with in_sof=1 sets hdr_cnt=1 and goes to HDR (the byte is header byte 0).
//   HDR:   pop, capture byte hdr_cnt, hdr_cnt++.
//          Checks: ethertype bytes 12..13 == 16'h0800 (ETH_HDR only); byte B == 8'h45; byte B+9 == 8'h11.
//          Captures: src_ip = bytes B+12..15; src_port = B+20..21; dst_port = B+22..23; udp_len = B+24..25 (big-endian).
//          After byte H-1 is popped:
//           - any check failed, dst_port not matched (FILTER_EN=1), or udp_len<=8: drop_count++; go to DRAIN.
//           - otherwise: pay_rem = udp_len-8 (16-bit); go to PAYLOAD.
//          in_eof seen before byte H-1: drop_count++; go to IDLE.
//   PAYLOAD: each pop drives out_wr_en=1 in the same cycle (zero latency, combinational from the pop) with out_din=in_dout.
//          out_sof=1 on the first payload byte only. pay_rem decrements on each pop.
//          Last payload byte (pay_rem==1): out_eof=1; pkt_count++; next state IDLE if in_eof, else DRAIN.
//          in_eof with pay_rem>1: out_eof=1, err_trunc=1, pkt_count++; next state IDLE.
//          in_sof inside a frame is ignored (treated as data).
//   DRAIN: pop and discard until a byte with in_eof=1, then go to IDLE. Padding and FCS bytes are removed here.
//  out_wr_en is never 1 while out_full==1. src_ip/src_port update only on accept.
//  Counters wrap modulo 2^CNT_WIDTH; pkt_count and drop_count never change in the same cycle.
// TESTING
//  1 ETH_HDR=1, PORT_LIST={5000,..}; frame with dst 5000, udp_len=12, payload DE AD BE EF -> 4 writes, out_sof on DE, out_eof on EF, pkt_count=1.
//  2 Same frame, dst port 6000 -> out_wr_en never 1; whole frame popped; drop_count=1; next valid frame forwarded normally.
//  3 udp_len=10, frame carries 6 trailing pad bytes after payload -> 2 writes, out_eof on 2nd; pad bytes popped in DRAIN; state IDLE after in_eof.
//  4 udp_len=20, in_eof on 5th payload byte -> 5 writes, out_eof and err_trunc=1 on 5th, pkt_count=1.
//  5 out_full toggled every 3 cycles during a 64-byte payload -> in_rd_en=0 whenever PAYLOAD && out_full; output bytes byte-exact and in order; header consumed while full.
//  6 reset=0 for one cycle mid-PAYLOAD -> all outputs 0 next cycle, counters 0; following frame with in_sof parsed and forwarded correctly.

Source files
------------

// File: rtl/udp_stream_parser.sv
// Byte-stream UDP/IPv4 receive parser: strips the Ethernet/IPv4/UDP headers, filters on
// destination port, forwards payload with sof/eof, trims padding and counts accept/drop.
module udp_stream_parser #(
  parameter bit                      ETH_HDR   = 1'b1,
  parameter bit                      FILTER_EN = 1'b1,
  parameter int                      NUM_PORTS = 4,
  parameter logic [NUM_PORTS*16-1:0] PORT_LIST = '0,
  parameter int                      CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_empty,
  input  logic [7:0]           in_dout,
  input  logic                 in_sof,
  input  logic                 in_eof,
  output logic                 in_rd_en,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [7:0]           out_din,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic [31:0]          src_ip,
  output logic [15:0]          src_port,
  output logic                 err_trunc,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int B = ETH_HDR ? 14 : 0;
  localparam logic [5:0] IDX_VER   = 6'(B);
  localparam logic [5:0] IDX_PROTO = 6'(B + 9);
  localparam logic [5:0] IDX_SIP   = 6'(B + 12);
  localparam logic [5:0] IDX_SPORT = 6'(B + 20);
  localparam logic [5:0] IDX_DPORT = 6'(B + 22);
  localparam logic [5:0] IDX_ULEN  = 6'(B + 24);
  localparam logic [5:0] IDX_LAST  = 6'(B + 27);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DRAIN} state_t;

  state_t               state_q;
  logic [5:0]           hdr_cnt_q;
  logic                 hdr_ok_q;
  logic [31:0]          ip_tmp_q;
  logic [15:0]          sport_tmp_q;
  logic [15:0]          dport_q;
  logic [15:0]          ulen_q;
  logic [15:0]          pay_rem_q;
  logic                 first_q;
  logic [31:0]          src_ip_q;
  logic [15:0]          src_port_q;
  logic [CNT_WIDTH-1:0] pkt_q;
  logic [CNT_WIDTH-1:0] drop_q;

  logic [5:0] idx;
  logic       byte_ok;
  logic       accept;

  function automatic logic port_match(input logic [15:0] port);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (PORT_LIST[16*i +: 16] == port) hit = 1'b1;
    return hit;
  endfunction

  // Byte 0 is popped in IDLE, so the header index is forced to 0 there.
  assign idx = (state_q == S_HDR) ? hdr_cnt_q : 6'd0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    byte_ok = 1'b1;
    if (ETH_HDR && idx == 6'd12 && in_dout != 8'h08) byte_ok = 1'b0;
    if (ETH_HDR && idx == 6'd13 && in_dout != 8'h00) byte_ok = 1'b0;
    if (idx == IDX_VER   && in_dout != 8'h45)        byte_ok = 1'b0;
    if (idx == IDX_PROTO && in_dout != 8'h11)        byte_ok = 1'b0;
  end

  assign accept = hdr_ok_q && byte_ok && (ulen_q > 16'd8) &&
                  (!FILTER_EN || port_match(dport_q));

  // Payload path is combinational so a pop and its write land in the same cycle.
  assign in_rd_en  = !in_empty && (state_q != S_PAYLOAD || !out_full);
  assign out_wr_en = in_rd_en && (state_q == S_PAYLOAD);
  assign out_din   = out_wr_en ? in_dout : 8'h00;
  assign out_sof   = out_wr_en && first_q;
  assign out_eof   = out_wr_en && (pay_rem_q == 16'd1 || in_eof);
  assign err_trunc = out_wr_en && in_eof && (pay_rem_q != 16'd1);

  assign src_ip     = src_ip_q;
  assign src_port   = src_port_q;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hdr_cnt_q   <= '0;
      hdr_ok_q    <= 1'b0;
      ip_tmp_q    <= '0;
      sport_tmp_q <= '0;
      dport_q     <= '0;
      ulen_q      <= '0;
      pay_rem_q   <= '0;
      first_q     <= 1'b0;
      src_ip_q    <= '0;
      src_port_q  <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
    end else if (in_rd_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_sof) begin
            hdr_cnt_q <= 6'd1;
            hdr_ok_q  <= byte_ok;
            if (in_eof) drop_q  <= drop_q + CNT_ONE;
            else        state_q <= S_HDR;
          end
        end
        S_HDR: begin
          hdr_cnt_q <= hdr_cnt_q + 6'd1;
          hdr_ok_q  <= hdr_ok_q & byte_ok;
          if (idx >= IDX_SIP && idx < IDX_SIP + 6'd4)
            ip_tmp_q <= {ip_tmp_q[23:0], in_dout};
          if (idx == IDX_SPORT || idx == IDX_SPORT + 6'd1)
            sport_tmp_q <= {sport_tmp_q[7:0], in_dout};
          if (idx == IDX_DPORT || idx == IDX_DPORT + 6'd1)
            dport_q <= {dport_q[7:0], in_dout};
          if (idx == IDX_ULEN || idx == IDX_ULEN + 6'd1)
            ulen_q <= {ulen_q[7:0], in_dout};
          if (in_eof) begin
            drop_q  <= drop_q + CNT_ONE;
            state_q <= S_IDLE;
          end else if (idx == IDX_LAST) begin
            if (accept) begin
              pay_rem_q  <= ulen_q - 16'd8;
              first_q    <= 1'b1;
              src_ip_q   <= ip_tmp_q;
              src_port_q <= sport_tmp_q;
              state_q    <= S_PAYLOAD;
            end else begin
              drop_q  <= drop_q + CNT_ONE;
              state_q <= S_DRAIN;
            end
          end
        end
        S_PAYLOAD: begin
          pay_rem_q <= pay_rem_q - 16'd1;
          first_q   <= 1'b0;
          if (pay_rem_q == 16'd1) begin
            pkt_q   <= pkt_q + CNT_ONE;
            state_q <= in_eof ? S_IDLE : S_DRAIN;
          end else if (in_eof) begin
            pkt_q   <= pkt_q + CNT_ONE;
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (in_eof) state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_stream_parser.sv
// Directed self-checking bench for udp_stream_parser: models a first-word-fall-through
// input FIFO and an output FIFO with a controllable full flag.
module tb_udp_stream_parser;

  localparam logic [1:0] K_HDR = 2'd0, K_PAY = 2'd1, K_PAD = 2'd2;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic [1:0] kind;
  } ibyte_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_empty;
  logic [7:0]  in_dout;
  logic        in_sof;
  logic        in_eof;
  logic        in_rd_en;
  logic        out_full;
  logic        out_wr_en;
  logic [7:0]  out_din;
  logic        out_sof;
  logic        out_eof;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic        err_trunc;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  ibyte_t     src_q[$];
  logic [7:0] cap_d[$];
  logic       cap_sof[$];
  logic       cap_eof[$];
  logic       cap_tr[$];
  logic [7:0] pay[$];
  logic [7:0] exp_b[$];

  udp_stream_parser #(
    .ETH_HDR   (1'b1),
    .FILTER_EN (1'b1),
    .NUM_PORTS (4),
    .PORT_LIST (64'h0000_0000_1B58_1388),
    .CNT_WIDTH (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .in_sof     (in_sof),
    .in_eof     (in_eof),
    .in_rd_en   (in_rd_en),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .out_din    (out_din),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .src_ip     (src_ip),
    .src_port   (src_port),
    .err_trunc  (err_trunc),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] sip, input logic [15:0] sport,
                            input logic [15:0] dport, input logic [15:0] ulen,
                            input logic [7:0] proto, input int npad, input bit acc);
    logic [7:0] h[$];
    logic [15:0] tlen;
    ibyte_t b;
    int total;
    tlen = ulen + 16'd20;
    for (int i = 0; i < 6; i++) h.push_back(8'hFF);
    for (int i = 0; i < 6; i++) h.push_back(8'h02);
    h.push_back(8'h08); h.push_back(8'h00);
    h.push_back(8'h45); h.push_back(8'h00); h.push_back(tlen[15:8]); h.push_back(tlen[7:0]);
    h.push_back(8'h00); h.push_back(8'h00); h.push_back(8'h40); h.push_back(8'h00);
    h.push_back(8'h40); h.push_back(proto); h.push_back(8'h00); h.push_back(8'h00);
    h.push_back(sip[31:24]); h.push_back(sip[23:16]); h.push_back(sip[15:8]); h.push_back(sip[7:0]);
    h.push_back(8'hC0); h.push_back(8'hA8); h.push_back(8'h01); h.push_back(8'h01);
    h.push_back(sport[15:8]); h.push_back(sport[7:0]);
    h.push_back(dport[15:8]); h.push_back(dport[7:0]);
    h.push_back(ulen[15:8]);  h.push_back(ulen[7:0]);
    h.push_back(8'h00); h.push_back(8'h00);
    total = h.size() + pay.size() + npad;
    for (int i = 0; i < total; i++) begin
      if (i < h.size()) begin
        b.d = h[i]; b.kind = K_HDR;
      end else if (i < h.size() + pay.size()) begin
        b.d = pay[i - h.size()]; b.kind = acc ? K_PAY : K_PAD;
      end else begin
        b.d = 8'h00; b.kind = K_PAD;
      end
      b.sof = (i == 0);
      b.eof = (i == total - 1);
      src_q.push_back(b);
    end
  endtask

  task automatic step(input logic full);
    ibyte_t h;
    logic   rd;
    @(negedge clk);
    out_full = full;
    if (src_q.size() > 0) begin
      h = src_q[0];
      in_empty = 1'b0; in_dout = h.d; in_sof = h.sof; in_eof = h.eof;
    end else begin
      h = '{d: 8'h00, sof: 1'b0, eof: 1'b0, kind: K_PAD};
      in_empty = 1'b1; in_dout = 8'h00; in_sof = 1'b0; in_eof = 1'b0;
    end
    #1;
    rd = in_rd_en;
    if (out_wr_en) begin
      cap_d.push_back(out_din); cap_sof.push_back(out_sof);
      cap_eof.push_back(out_eof); cap_tr.push_back(err_trunc);
    end
    if (out_wr_en && full) viol++;
    if (rd !== (!in_empty && !(full && h.kind == K_PAY))) viol++;
    @(posedge clk);
    if (rd) void'(src_q.pop_front());
  endtask

  task automatic run_frame(input string tag, input bit toggle_full);
    int cyc;
    cyc = 0;
    while (src_q.size() > 0 && cyc < 2000) begin
      step(toggle_full ? ((cyc / 3) % 2 == 0) : 1'b0);
      cyc++;
    end
    check({tag, "_popped_all"}, src_q.size(), 0);
    @(negedge clk);
    in_empty = 1'b1; out_full = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    #1;
  endtask

  task automatic check_out(input string tag, input logic exp_tr);
    check({tag, "_nwrites"}, cap_d.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < cap_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), cap_d[i], exp_b[i]);
      check($sformatf("%s_sof%0d", tag, i), cap_sof[i], i == 0);
      check($sformatf("%s_eof%0d", tag, i), cap_eof[i], i == exp_b.size() - 1);
      check($sformatf("%s_trunc%0d", tag, i), cap_tr[i], exp_tr && (i == exp_b.size() - 1));
    end
    check({tag, "_flow_ctrl"}, viol, 0);
    cap_d.delete(); cap_sof.delete(); cap_eof.delete(); cap_tr.delete();
    viol = 0;
  endtask

  initial begin
    ibyte_t g;
    reset = 1'b0; in_empty = 1'b1; in_dout = 8'h00; in_sof = 1'b0; in_eof = 1'b0;
    out_full = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_rd_en", in_rd_en, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_din", out_din, 0);
    check("rst_sof_eof_trunc", {out_sof, out_eof, err_trunc}, 0);
    check("rst_src_ip", src_ip, 0);
    check("rst_src_port", src_port, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_drop", drop_count, 0);

    // Basic accept on the first listed port.
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_frame(32'hC0A8010A, 16'h04D2, 16'd5000, 16'd12, 8'h11, 0, 1'b1);
    run_frame("t1", 1'b0);
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    check_out("t1", 1'b0);
    check("t1_pkt", pkt_count, 1);
    check("t1_drop", drop_count, 0);
    check("t1_src_ip", src_ip, 32'hC0A8010A);
    check("t1_src_port", src_port, 16'h04D2);

    // Unlisted port is drained and dropped; next frame on the second entry is accepted.
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_frame(32'hC0A80163, 16'h9999, 16'd6000, 16'd12, 8'h11, 0, 1'b0);
    run_frame("t2", 1'b0);
    exp_b = '{};
    check_out("t2", 1'b0);
    check("t2_drop", drop_count, 1);
    check("t2_pkt", pkt_count, 1);
    check("t2_src_port_held", src_port, 16'h04D2);
    check("t2_src_ip_held", src_ip, 32'hC0A8010A);
    pay = '{8'h11, 8'h22, 8'h33};
    push_frame(32'hC0A80114, 16'h1F90, 16'd7000, 16'd11, 8'h11, 0, 1'b1);
    run_frame("t2b", 1'b0);
    exp_b = '{8'h11, 8'h22, 8'h33};
    check_out("t2b", 1'b0);
    check("t2b_pkt", pkt_count, 2);
    check("t2b_src_ip", src_ip, 32'hC0A80114);
    check("t2b_src_port", src_port, 16'h1F90);

    // Stray non-sof bytes in IDLE, then a short datagram followed by link padding.
    g = '{d: 8'h55, sof: 1'b0, eof: 1'b0, kind: K_PAD}; src_q.push_back(g);
    g = '{d: 8'h66, sof: 1'b0, eof: 1'b1, kind: K_PAD}; src_q.push_back(g);
    g = '{d: 8'h77, sof: 1'b0, eof: 1'b0, kind: K_PAD}; src_q.push_back(g);
    pay = '{8'hA1, 8'hA2};
    push_frame(32'hC0A8010B, 16'h0101, 16'd5000, 16'd10, 8'h11, 6, 1'b1);
    run_frame("t3", 1'b0);
    exp_b = '{8'hA1, 8'hA2};
    check_out("t3", 1'b0);
    check("t3_pkt", pkt_count, 3);
    check("t3_drop", drop_count, 1);

    // Frame ends after 5 of 12 payload bytes.
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push_frame(32'hC0A8010C, 16'h0202, 16'd5000, 16'd20, 8'h11, 0, 1'b1);
    run_frame("t4", 1'b0);
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_out("t4", 1'b1);
    check("t4_pkt", pkt_count, 4);

    // Non-UDP protocol and udp_len == 8 are both dropped.
    pay = '{8'h99, 8'h98};
    push_frame(32'hC0A8010D, 16'h0303, 16'd5000, 16'd10, 8'h06, 0, 1'b0);
    run_frame("t4b", 1'b0);
    pay = '{};
    push_frame(32'hC0A8010E, 16'h0404, 16'd5000, 16'd8, 8'h11, 2, 1'b0);
    run_frame("t4c", 1'b0);
    exp_b = '{};
    check_out("t4bc", 1'b0);
    check("t4bc_drop", drop_count, 3);
    check("t4bc_pkt", pkt_count, 4);
    check("t4bc_src_port_held", src_port, 16'h0202);

    // 64-byte payload with out_full toggling every 3 cycles.
    pay = '{};
    exp_b = '{};
    for (int i = 0; i < 64; i++) begin
      pay.push_back(8'(i * 7 + 3));
      exp_b.push_back(8'(i * 7 + 3));
    end
    push_frame(32'hC0A8010F, 16'h0505, 16'd5000, 16'd72, 8'h11, 4, 1'b1);
    run_frame("t5", 1'b1);
    check_out("t5", 1'b0);
    check("t5_pkt", pkt_count, 5);

    // Reset asserted mid-payload; leftover bytes lack sof and must be discarded.
    pay = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    push_frame(32'hC0A80110, 16'h0606, 16'd5000, 16'd18, 8'h11, 0, 1'b1);
    for (int i = 0; i < 45; i++) step(1'b0);
    check("t6_partial_writes", cap_d.size(), 3);
    @(negedge clk);
    in_empty = 1'b1; in_sof = 1'b0; in_eof = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_wr_en", out_wr_en, 0);
    check("t6_outs", {out_din, out_sof, out_eof, err_trunc}, 0);
    check("t6_src", {src_ip, src_port}, 0);
    check("t6_pkt", pkt_count, 0);
    check("t6_drop", drop_count, 0);
    cap_d.delete(); cap_sof.delete(); cap_eof.delete(); cap_tr.delete();
    viol = 0;
    pay = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    push_frame(32'hC0A80111, 16'h0707, 16'd5000, 16'd12, 8'h11, 0, 1'b1);
    run_frame("t6b", 1'b0);
    exp_b = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    check_out("t6b", 1'b0);
    check("t6b_pkt", pkt_count, 1);
    check("t6b_drop", drop_count, 0);
    check("t6b_src_port", src_port, 16'h0707);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
